down_timer: RTL and testbench
=============================

# down_timer

Loadable down-counting timer, the countdown counterpart of the team's 4-bit enabled up-counter. A start value is loaded, the timer decrements by one on each enabled clock, and it flags terminal count with a one-cycle pulse. In one-shot mode it halts at zero; in auto-reload mode it restarts from the loaded value. It serves as the timeout and periodic-tick source next to the up-counter in the same clock domain.

## Interface
- WIDTH, default 4: counter and load value width in bits, valid range 2 to 16.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  loads load_value and arms the timer; takes priority over everything except reset.
- load_value  input  WIDTH  start value, sampled only when load=1.
- enable  input  1  decrements by one per clock when high in RUN; holds when low.
- auto_reload  input  1  level, sampled at terminal count: 1 = reload and continue, 0 = one-shot.
- count_out  output  WIDTH  current count, registered.
- busy  output  1  high while in RUN.
- done  output  1  level, high in DONE (one-shot expired) until the next load.
- tc_pulse  output  1  registered pulse, high for exactly one cycle per terminal count.

## Operation
- States: IDLE, RUN, DONE.
- Reset (asynchronous, any time, including mid-count): state IDLE, count_out=0, reload register=0, busy=0, done=0, tc_pulse=0.
- load=1, any state: count_out<=load_value, reload register<=load_value, tc_pulse<=0, done<=0. Next state is RUN if load_value!=0, otherwise IDLE. A zero load never produces tc_pulse.
- RUN, enable=1, count_out>1: count_out<=count_out-1.
- RUN, enable=1, count_out==1 (terminal count): tc_pulse<=1. If auto_reload=1, count_out<=reload register and state stays RUN. If auto_reload=0, count_out<=0 and state goes to DONE.
- RUN, enable=0: all state held, tc_pulse<=0.
- DONE: count_out held at 0, done=1, enable ignored. Only load or reset exits DONE.
- IDLE: count_out held, enable ignored.
- Simultaneous load and terminal count: load wins and tc_pulse stays 0.
- Arithmetic is unsigned, modulo 2^WIDTH. The count never wraps below 0 because terminal count is detected at 1. load_value=2^WIDTH-1 is legal.

## Timing
- All outputs are registered. busy and done are decoded from the state register, with no combinational path from inputs to outputs.
- load at edge k: count_out=load_value and busy=1 after edge k.
- Loaded N>0 with enable held high: tc_pulse is high in the cycle after the edge where the count goes from 1 to its next value, which is N enabled edges after the load edge.
- Auto-reload period is exactly N enabled cycles between tc_pulse assertions. count_out reads N, N-1, ..., 1, N, ... and never shows 0.
- tc_pulse is high for one cycle only, even if enable stays high.

## Structure
- The shared package holds the state enum (IDLE, RUN, DONE) and the WIDTH default constant. The up-counter may reuse the width constant.
- Single module with no sub-module. Next-state/datapath logic is one clocked process with asynchronous reset; the state decode for busy and done is a small combinational block.

## Test plan
- Reset mid-count: load 9, run 3 enabled cycles, pulse reset_n low between edges -> count_out=0, busy=0, done=0, tc_pulse=0 immediately, and they hold at those values.
- One-shot: load 5, auto_reload=0, enable high -> count_out reads 5,4,3,2,1,0; tc_pulse high for exactly one cycle as count_out reaches 0; done=1 and busy=0 afterwards; count stays 0 with enable still high.
- Auto-reload: load 3, auto_reload=1, enable high for 10 cycles -> count_out reads 3,2,1,3,2,1,...; tc_pulse is high once every 3 cycles.
- Enable gaps: load 4, toggle enable 1,0,0,1,1,1 -> count_out holds on the low cycles; tc_pulse occurs after the 4th enabled cycle.
- Zero load and load collision: load 0 -> stays IDLE with no tc_pulse. Load 2, run to count_out=1, then assert load with load_value=7 on the terminal edge -> count_out=7, tc_pulse=0, busy=1.
- Maximum value with WIDTH=4: load 15, auto_reload=0 -> tc_pulse after exactly 15 enabled cycles, and no wrap to 15 after reaching 0.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer and its companion up-counter.
//   DEFAULT_WIDTH : default counter width in bits
//   state_t       : timer state encoding (IDLE, RUN, DONE)
package down_timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes and a
// one-cycle terminal-count pulse.
//   clk         : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   load        : load load_value and arm (highest priority after reset)
//   load_value  : start value, sampled only while load=1
//   enable      : decrement one per clock while in RUN
//   auto_reload : at terminal count, 1 = reload and continue, 0 = halt in DONE
//   count_out   : current count (registered)
//   busy        : high while in RUN (decoded from state register)
//   done        : high in DONE until the next load (decoded from state register)
//   tc_pulse    : registered one-cycle pulse per terminal count
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // State, count, reload and pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state and datapath; terminal count is detected at 1 so the
  // count never wraps below zero.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        DONE:    count_d = '0;
        default: ;
      endcase
    end
  end

  // State decode
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign count_out = count_q;
  assign tc_pulse  = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer (WIDTH=4).
module tb_down_timer;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset_n;
  logic         load;
  logic [W-1:0] load_value;
  logic         enable;
  logic         auto_reload;
  logic [W-1:0] count_out;
  logic         busy;
  logic         done;
  logic         tc_pulse;

  int passed = 0;
  int total  = 0;

  down_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .auto_reload(auto_reload),
    .count_out  (count_out),
    .busy       (busy),
    .done       (done),
    .tc_pulse   (tc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] c, input logic b,
                         input logic d, input logic t);
    chk({tag, ".count"}, 16'(count_out), 16'(c));
    chk({tag, ".busy"},  16'(busy),      16'(b));
    chk({tag, ".done"},  16'(done),      16'(d));
    chk({tag, ".tc"},    16'(tc_pulse),  16'(t));
  endtask

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] exp_c;
    logic         exp_t;
    logic         en_seq [6];

    reset_n     = 1'b0;
    load        = 1'b0;
    load_value  = '0;
    enable      = 1'b0;
    auto_reload = 1'b0;
    #12;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;

    // Reset mid-count
    load = 1'b1; load_value = 4'd9;
    tick();
    load = 1'b0; enable = 1'b1;
    chk_all("rst_mid.load", 4'd9, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("rst_mid.run3", 16'(count_out), 16'd6);
    #2 reset_n = 1'b0;
    #1;
    chk_all("rst_mid.async", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk_all("rst_mid.hold", 4'd0, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b1;

    // One-shot from 5
    auto_reload = 1'b0; enable = 1'b1;
    load = 1'b1; load_value = 4'd5;
    tick();
    load = 1'b0;
    chk_all("oneshot.load", 4'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk_all("oneshot.dec", W'(i), 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_all("oneshot.tc", 4'd0, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    chk_all("oneshot.halt", 4'd0, 1'b0, 1'b1, 1'b0);

    // Auto-reload from 3
    auto_reload = 1'b1;
    load = 1'b1; load_value = 4'd3;
    tick();
    load = 1'b0;
    chk_all("auto.load", 4'd3, 1'b1, 1'b0, 1'b0);
    exp_c = 4'd3;
    for (int i = 0; i < 10; i++) begin
      exp_t = (exp_c == 4'd1);
      exp_c = (exp_c == 4'd1) ? 4'd3 : exp_c - 4'd1;
      tick();
      chk_all("auto.cycle", exp_c, 1'b1, 1'b0, exp_t);
    end

    // Enable gaps from 4
    auto_reload = 1'b0; enable = 1'b0;
    load = 1'b1; load_value = 4'd4;
    tick();
    load = 1'b0;
    chk_all("gap.load", 4'd4, 1'b1, 1'b0, 1'b0);
    en_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_c = 4'd4;
    for (int i = 0; i < 6; i++) begin
      enable = en_seq[i];
      tick();
      exp_t = en_seq[i] && (exp_c == 4'd1);
      if (en_seq[i]) exp_c = exp_c - 4'd1;
      chk_all("gap.step", exp_c, exp_c != 4'd0, exp_c == 4'd0, exp_t);
    end

    // Zero load: leaves DONE, goes IDLE, never pulses
    enable = 1'b1;
    load = 1'b1; load_value = 4'd0;
    tick();
    load = 1'b0;
    chk_all("zero.load", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk_all("zero.idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // Load colliding with terminal count
    load = 1'b1; load_value = 4'd2;
    tick();
    load = 1'b0;
    chk_all("coll.load", 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("coll.at1", 4'd1, 1'b1, 1'b0, 1'b0);
    load = 1'b1; load_value = 4'd7;
    tick();
    load = 1'b0;
    chk_all("coll.reload", 4'd7, 1'b1, 1'b0, 1'b0);

    // Maximum value one-shot
    enable = 1'b0;
    load = 1'b1; load_value = 4'd15;
    tick();
    load = 1'b0; enable = 1'b1;
    chk_all("max.load", 4'd15, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk_all("max.step", W'(15 - i), i != 15, i == 15, i == 15);
    end
    tick(); tick(); tick();
    chk_all("max.nowrap", 4'd0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
